// File: rtl/timer_pkg.sv
// Shared types and constants for the interval timer and its users.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } timer_state_t;

    localparam logic TIMER_ONESHOT  = 1'b0;
    localparam logic TIMER_PERIODIC = 1'b1;

endpackage

// File: rtl/interval_timer_tick_prescaler.sv
// Tick prescaler: emits one single-cycle tick every PRESCALE enabled cycles.
// Only instantiated by interval_timer when TIMER_PRESCALE_EN is defined.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Tick on the last enabled cycle of each group; clear restarts the group.
    always_comb begin
        cnt_d  = cnt_q;
        tick_o = enable_i && (cnt_q == LAST);
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Prescale counter register with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/interval_timer.sv
// Programmable interval timer: counts ticks from 0 up to a latched limit,
// then stops (one-shot) or reloads (periodic), pulsing Done at each terminal.
// Optional feature macro: TIMER_PRESCALE_EN (divides ticks by PRESCALE).
module interval_timer
    import timer_pkg::*;
#(
    parameter int WIDTH    = 11,
    parameter int PRESCALE = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Mode,
    input  logic [WIDTH-1:0] Limit,
    output logic [WIDTH-1:0] Count,
    output logic             Running,
    output logic             Done,
    output logic             Expired
);

    if (WIDTH < 2 || WIDTH > 32 || PRESCALE < 1) begin : gParamCheck
        $error("interval_timer: WIDTH must be 2..32 and PRESCALE at least 1");
    end

    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;

    logic runEnable;
    logic tick;
    logic atTerminal;

    // Start and Stop cycles never count as ticks, so Count freezes on Stop.
    assign runEnable  = (state_q == RUN) && Enable && !Start && !Stop;
    assign atTerminal = (count_q == limit_q);

`ifdef TIMER_PRESCALE_EN
    logic prescaleClear;
    assign prescaleClear = Start || Stop;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) uPrescaler (
        .Clock   (Clock),
        .Reset   (Reset),
        .clear_i (prescaleClear),
        .enable_i(runEnable),
        .tick_o  (tick)
    );
`else
    assign tick = runEnable;
`endif

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: Start wins from anywhere, Stop only leaves RUN.
    always_comb begin
        state_d = state_q;
        if (Start) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (Stop) begin
                        state_d = IDLE;
                    end else if (tick && atTerminal && (mode_q == TIMER_ONESHOT)) begin
                        state_d = EXPIRED;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath next values: latch on Start, advance or reload on ticks.
    always_comb begin
        count_d = count_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        if (Start) begin
            limit_d = Limit;
            mode_d  = Mode;
            count_d = '0;
        end else if (tick) begin
            if (atTerminal) begin
                done_d = 1'b1;
                if (mode_q == TIMER_PERIODIC) begin
                    count_d = '0;
                end
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q <= '0;
            limit_q <= '0;
            mode_q  <= TIMER_ONESHOT;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    // Outputs come straight from registers; status is decoded from state.
    always_comb begin
        Count   = count_q;
        Done    = done_q;
        Running = (state_q == RUN);
        Expired = (state_q == EXPIRED);
    end

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: directed scenarios with literal
// expectations plus a randomized phase, all checked against a behavioural model.
module tb_interval_timer;

    localparam int WIDTH = 11;
`ifdef TIMER_PRESCALE_EN
    localparam int PS = 3;
`else
    localparam int PS = 1;
`endif

    logic             Clock = 1'b0;
    logic             Reset = 1'b0;
    logic             Enable = 1'b0;
    logic             Start = 1'b0;
    logic             Stop = 1'b0;
    logic             Mode = 1'b0;
    logic [WIDTH-1:0] Limit = '0;
    logic [WIDTH-1:0] Count;
    logic             Running;
    logic             Done;
    logic             Expired;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    // Behavioural model state.
    int mCount = 0;
    int mLimit = 0;
    bit mPeriodic = 1'b0;
    bit mActive = 1'b0;
    bit mExpired = 1'b0;
    bit mDone = 1'b0;
    int mPre = 0;

    interval_timer #(
        .WIDTH   (WIDTH),
        .PRESCALE(PS)
    ) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Enable (Enable),
        .Start  (Start),
        .Stop   (Stop),
        .Mode   (Mode),
        .Limit  (Limit),
        .Count  (Count),
        .Running(Running),
        .Done   (Done),
        .Expired(Expired)
    );

    // Free-running clock.
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: apply the timer rules to the inputs seen at each rising edge.
    always @(posedge Clock) begin
        bit tickNow;
        tickNow = 1'b0;
        if (Reset) begin
            mCount = 0; mLimit = 0; mPeriodic = 0;
            mActive = 0; mExpired = 0; mDone = 0; mPre = 0;
        end else if (Start) begin
            mLimit = int'(Limit); mPeriodic = Mode; mCount = 0;
            mExpired = 0; mActive = 1; mPre = 0; mDone = 0;
        end else if (mActive && Stop) begin
            mActive = 0; mPre = 0; mDone = 0;
        end else if (mActive && Enable) begin
            mPre = mPre + 1;
            if (mPre == PS) begin
                mPre = 0;
                tickNow = 1'b1;
            end
            mDone = 0;
            if (tickNow) begin
                if (mCount == mLimit) begin
                    mDone = 1;
                    if (mPeriodic) mCount = 0;
                    else begin
                        mActive = 0;
                        mExpired = 1;
                    end
                end else begin
                    mCount = mCount + 1;
                end
            end
        end else begin
            mDone = 0;
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge Clock) begin
        if (checkEn) begin
            checkOutput("model_count", 32'(Count), 32'(mCount));
            checkOutput("model_done", 32'(Done), 32'(mDone));
            checkOutput("model_running", 32'(Running), 32'(mActive));
            checkOutput("model_expired", 32'(Expired), 32'(mExpired));
        end
    end

    task automatic applyStimulus(input logic r, input logic e, input logic s, input logic p,
                                 input logic m, input logic [WIDTH-1:0] l);
        Reset = r; Enable = e; Start = s; Stop = p; Mode = m; Limit = l;
        @(posedge Clock);
        #2;
    endtask

    // Non-command cycle with junk on Mode/Limit, which must be ignored.
    task automatic idleCycle(input logic e);
        applyStimulus(1'b0, e, 1'b0, 1'b0, 1'($urandom), WIDTH'($urandom));
    endtask

    task automatic startTimer(input logic m, input logic [WIDTH-1:0] l);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, m, l);
    endtask

    // Advance with Enable high until Done is seen or the bound runs out.
    task automatic waitDone(input int bound, output int n);
        n = 0;
        while (n < bound) begin
            idleCycle(1'b1);
            n++;
            if (Done === 1'b1) break;
        end
    endtask

    initial begin
        int n;
        int pulses;
        int lastPulse;
        int expSeq[6];
        logic [WIDTH-1:0] lim;

        expSeq = '{0, 1, 2, 3, 4, 0};
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkEn = 1'b1;
        checkOutput("reset_count", 32'(Count), 32'd0);
        checkOutput("reset_running", 32'(Running), 32'd0);
        checkOutput("reset_done", 32'(Done), 32'd0);
        checkOutput("reset_expired", 32'(Expired), 32'd0);

`ifndef TIMER_PRESCALE_EN
        // Full-range one-shot.
        startTimer(1'b0, 11'd2047);
        checkOutput("s1_start_count", 32'(Count), 32'd0);
        checkOutput("s1_start_running", 32'(Running), 32'd1);
        waitDone(2100, n);
        checkOutput("s1_done_latency", 32'(n), 32'd2048);
        checkOutput("s1_hold_count", 32'(Count), 32'd2047);
        checkOutput("s1_expired", 32'(Expired), 32'd1);
        checkOutput("s1_running", 32'(Running), 32'd0);
        idleCycle(1'b1);
        checkOutput("s1_done_single", 32'(Done), 32'd0);

        // Periodic, limit 4.
        startTimer(1'b1, 11'd4);
        pulses = 0; lastPulse = 0;
        checkOutput("s2_seq0", 32'(Count), 32'(expSeq[0]));
        for (int i = 1; i <= 20; i++) begin
            idleCycle(1'b1);
            if (i < 6) checkOutput("s2_seq", 32'(Count), 32'(expSeq[i]));
            if (Done === 1'b1) begin
                if (lastPulse != 0) checkOutput("s2_gap", 32'(i - lastPulse), 32'd5);
                pulses++;
                lastPulse = i;
            end
        end
        checkOutput("s2_pulses", 32'(pulses), 32'd4);

        // One-shot with a 3-cycle pause.
        startTimer(1'b0, 11'd10);
        repeat (4) idleCycle(1'b1);
        checkOutput("s3_count4", 32'(Count), 32'd4);
        repeat (3) idleCycle(1'b0);
        checkOutput("s3_paused", 32'(Count), 32'd4);
        checkOutput("s3_paused_run", 32'(Running), 32'd1);
        waitDone(20, n);
        checkOutput("s3_done_latency", 32'(4 + 3 + n), 32'd14);

        // Stop at Count 6.
        startTimer(1'b0, 11'd10);
        repeat (6) idleCycle(1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd10);
        checkOutput("s3_stop_count", 32'(Count), 32'd6);
        checkOutput("s3_stop_running", 32'(Running), 32'd0);
        pulses = 0;
        repeat (12) begin
            idleCycle(1'b1);
            if (Done === 1'b1) pulses++;
        end
        checkOutput("s3_stop_nodone", 32'(pulses), 32'd0);
        checkOutput("s3_stop_frozen", 32'(Count), 32'd6);

        // Restart at Count 7 with Start and Stop together.
        startTimer(1'b0, 11'd10);
        repeat (7) idleCycle(1'b1);
        checkOutput("s4_count7", 32'(Count), 32'd7);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 11'd2);
        checkOutput("s4_restart_count", 32'(Count), 32'd0);
        checkOutput("s4_restart_running", 32'(Running), 32'd1);
        checkOutput("s4_restart_expired", 32'(Expired), 32'd0);
        waitDone(10, n);
        checkOutput("s4_done_latency", 32'(n), 32'd3);
        checkOutput("s4_expired", 32'(Expired), 32'd1);

        // Limit 0 periodic, then reset mid-run.
        startTimer(1'b1, 11'd0);
        pulses = 0;
        repeat (5) begin
            idleCycle(1'b1);
            if (Done === 1'b1) pulses++;
        end
        checkOutput("s5_every_cycle", 32'(pulses), 32'd5);
        checkOutput("s5_count", 32'(Count), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 11'd5);
        checkOutput("s5_reset_count", 32'(Count), 32'd0);
        checkOutput("s5_reset_running", 32'(Running), 32'd0);
        checkOutput("s5_reset_done", 32'(Done), 32'd0);
        checkOutput("s5_reset_expired", 32'(Expired), 32'd0);
`else
        // Prescale 3, limit 1, one-shot.
        begin
            int expCnt[5];
            expCnt = '{0, 0, 1, 1, 1};
            startTimer(1'b0, 11'd1);
            for (int i = 0; i < 5; i++) begin
                idleCycle(1'b1);
                checkOutput("s6_count", 32'(Count), 32'(expCnt[i]));
                checkOutput("s6_nodone", 32'(Done), 32'd0);
            end
            idleCycle(1'b1);
            checkOutput("s6_done", 32'(Done), 32'd1);
            checkOutput("s6_expired", 32'(Expired), 32'd1);
        end
`endif

        // Randomized phase.
        for (int i = 0; i < 4000; i++) begin
            lim = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 12));
            applyStimulus(($urandom_range(0, 299) == 0),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 15) == 0),
                          1'($urandom), lim);
        end

        idleCycle(1'b0);
        checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
